// File: rtl/mux_sel_rr_arb.sv
// Round-robin select generator for a 4:1 mux stage.
// A grant holds for HOLD_CYCLES acknowledged samples, or ends early if the
// granted channel withdraws its request. Rotation then continues from the
// channel after the last winner. Every output comes straight from a flop.
// Optional feature: define MUX_SEL_LOCK_EN to add lock_i. While lock_i is
// high, the beat-count rotation is held off.
//
// state | meaning
// IDLE  | no live grant, valid_o=0, sel_o keeps last value
// GRANT | sel_o/grant_o drive a requesting channel, valid_o=busy_o=1
module mux_sel_rr_arb #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [3:0] req_i,
  input  logic       ack_i,
`ifdef MUX_SEL_LOCK_EN
  input  logic       lock_i,
`endif
  output logic [1:0] sel_o,
  output logic [3:0] grant_o,
  output logic       valid_o,
  output logic       busy_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       grant_q, grant_d;
  logic             lock;
  logic [2:0]       pick;
  logic             last_beat;
  logic             end_hold;
  logic             end_wd;

`ifdef MUX_SEL_LOCK_EN
  assign lock = lock_i;
`else
  assign lock = 1'b0;
`endif

  // Return {found, index} for the first requester after ptr, wrapping mod 4.
  // The loop walks from the farthest offset to the nearest, so the nearest requester wins.
  // Offset 4 wraps back to ptr itself, so the last winner has the lowest priority.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Grant-termination conditions and the round-robin winner for this cycle.
  always_comb begin
    pick      = rr_pick(req_i, ptr_q);
    last_beat = (cnt_q == CNT_LAST);
    end_hold  = ack_i && last_beat && !lock;
    end_wd    = !req_i[sel_q];
  end

  // State register: async reset; ptr starts at 3 so that channel 0 wins first.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      sel_q   <= 2'b00;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
      grant_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  // Next-state logic: arbitrate from IDLE, or re-arbitrate back-to-back when a grant ends.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (pick[2]) begin
          state_d = GRANT;
          sel_d   = pick[1:0];
          ptr_d   = pick[1:0];
          cnt_d   = '0;
          grant_d = 4'b0001 << pick[1:0];
        end
      end
      GRANT: begin
        if (end_hold || end_wd) begin
          cnt_d = '0;
          if (pick[2]) begin
            sel_d   = pick[1:0];
            ptr_d   = pick[1:0];
            grant_d = 4'b0001 << pick[1:0];
          end else begin
            state_d = IDLE;
            grant_d = 4'b0000;
          end
        end else if (ack_i && !last_beat) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: direct decode of registered state, no combinational input paths.
  always_comb begin
    sel_o   = sel_q;
    grant_o = grant_q;
    valid_o = (state_q == GRANT);
    busy_o  = (state_q == GRANT);
  end

endmodule

// File: tb/tb_mux_sel_rr_arb.sv
// Bench for mux_sel_rr_arb. A behavioural round-robin model runs alongside
// the DUT and is compared on every clock, plus literal scenario checks.
// Define MUX_SEL_LOCK_EN to also exercise lock_i.
module tb_mux_sel_rr_arb;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       ack = 1'b0;
  logic       lock = 1'b0;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       valid;
  logic       busy;

  int tests = 0;
  int fails = 0;

  int m_valid = 0;
  int m_sel   = 0;
  int m_ptr   = 3;
  int m_beats = 0;

  mux_sel_rr_arb #(.HOLD_CYCLES(H), .CNT_W(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .req_i   (req),
    .ack_i   (ack),
`ifdef MUX_SEL_LOCK_EN
    .lock_i  (lock),
`endif
    .sel_o   (sel),
    .grant_o (grant),
    .valid_o (valid),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Round-robin pick: first requesting channel at offsets 1..4 after ptr.
  function automatic int model_pick(input logic [3:0] r, input int ptr);
    for (int k = 1; k <= 4; k++) begin
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  // Reference model update, then comparison one time unit after the edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_sel = 0; m_ptr = 3; m_beats = 0;
    end else begin
      int  w;
      bit  done;
      w = model_pick(req, m_ptr);
      if (m_valid == 0) begin
        if (w >= 0) begin
          m_valid = 1; m_sel = w; m_ptr = w; m_beats = 0;
        end
      end else begin
        done = (req[m_sel] == 1'b0) || (ack && !lock && m_beats == H - 1);
        if (done) begin
          m_beats = 0;
          if (w >= 0) begin
            m_sel = w; m_ptr = w;
          end else begin
            m_valid = 0;
          end
        end else if (ack && m_beats < H - 1) begin
          m_beats++;
        end
      end
    end
    #1;
    chk("cmp_valid", int'(valid), m_valid);
    chk("cmp_busy",  int'(busy),  m_valid);
    chk("cmp_sel",   int'(sel),   m_sel);
    chk("cmp_grant", int'(grant), m_valid ? (1 << m_sel) : 0);
  end

  initial begin
    // reset held
    #12;
    chk("rst_valid", int'(valid), 0);
    chk("rst_sel",   int'(sel),   0);
    chk("rst_grant", int'(grant), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // idle with no requests for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_valid", int'(valid), 0);
      chk("idle_sel",   int'(sel),   0);
      chk("idle_grant", int'(grant), 0);
    end

    // all requesting, ack constant: 0,1,2,3,0 each for 4 cycles
    req = 4'b1111; ack = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("rot_sel",   int'(sel),   (k / 4) % 4);
      chk("rot_valid", int'(valid), 1);
    end

    // single requester ch2 keeps re-winning
    req = 4'b0100;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("solo_sel",   int'(sel),   2);
      chk("solo_valid", int'(valid), 1);
    end

    // idle holds last select
    req = 4'b0000; ack = 1'b0;
    @(negedge clk);
    chk("hold_valid", int'(valid), 0);
    chk("hold_sel",   int'(sel),   2);

    // ch1 grant, 2 beats, then withdraw with req=1001 -> ch3
    req = 4'b0010; ack = 1'b1;
    @(negedge clk);
    chk("wd_first", int'(sel), 1);
    @(negedge clk);
    @(negedge clk);
    chk("wd_still", int'(sel), 1);
    req = 4'b1001; ack = 1'b0;
    @(negedge clk);
    chk("wd_sel",   int'(sel),   3);
    chk("wd_valid", int'(valid), 1);
    req = 4'b0000;
    @(negedge clk);
    chk("wd_idle_valid", int'(valid), 0);
    chk("wd_idle_sel",   int'(sel),   3);
    chk("wd_idle_grant", int'(grant), 0);

    // ack toggling on ch0 with req=0011: rotates to ch1 on 4th acked beat
    req = 4'b0011; ack = 1'b0;
    @(negedge clk);
    chk("tog_first", int'(sel), 0);
    for (int i = 0; i < 7; i++) begin
      ack = (i % 2 == 0);
      @(negedge clk);
      chk("tog_sel", int'(sel), (i < 6) ? 0 : 1);
    end

    // asynchronous reset mid-grant
    ack = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", int'(valid), 0);
    chk("async_sel",   int'(sel),   0);
    chk("async_grant", int'(grant), 0);
    @(negedge clk);
    rst_n = 1'b1; req = 4'b0000; ack = 1'b0;

`ifdef MUX_SEL_LOCK_EN
    req = 4'b0100; ack = 1'b1; lock = 1'b0;
    @(negedge clk);
    chk("lock_first", int'(sel), 2);
    lock = 1'b1; req = 4'b0110;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("lock_hold", int'(sel), 2);
    end
    lock = 1'b0;
    @(negedge clk);
    chk("lock_release", int'(sel), 1);
`endif

    // randomized traffic against the model, with occasional async resets
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      ack = ($urandom_range(0, 2) != 0);
`ifdef MUX_SEL_LOCK_EN
      if ($urandom_range(0, 7) == 0) lock = ~lock;
`endif
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rnd_rst_valid", int'(valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
